// File: rtl/staircase_pwm_dac.sv
// PWM DAC stage for the 4-bit staircase generator: one level sample per 15-slot frame,
// with a per-frame strobe for the upstream step enable and wrap-around detection/counting.
module staircase_pwm_dac #(
    parameter int unsigned DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] level_in,
    output logic       pwm_out,
    output logic       frame_start,
    output logic [3:0] level_q,
    output logic       wrap,
    output logic [7:0] wrap_count
);

    localparam int unsigned PRE_W     = 16;
    localparam int unsigned SLOT_W    = 4;
    localparam int unsigned CNT_W     = 8;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(14);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(255);

    logic [PRE_W-1:0]  pre;
    logic [SLOT_W-1:0] slot;
    logic              tick_c;
    logic              boundary_c;
    logic              drop_c;

    assign tick_c     = en && (pre == PRE_LAST);
    assign boundary_c = tick_c && (slot == SLOT_LAST);
    assign drop_c     = level_in < level_q;

    // Prescaler and slot counter both freeze while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre  <= '0;
            slot <= '0;
        end else begin
            if (tick_c) begin
                pre  <= '0;
                slot <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
            end else if (en) begin
                pre <= pre + PRE_W'(1);
            end
        end
    end

    // Frame boundary: latch the new level, strobe, and detect the staircase drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q     <= '0;
            frame_start <= 1'b0;
            wrap        <= 1'b0;
            wrap_count  <= '0;
        end else begin
            frame_start <= 1'b0;
            wrap        <= 1'b0;
            if (boundary_c) begin
                level_q     <= level_in;
                frame_start <= 1'b1;
                wrap        <= drop_c;
                if (drop_c && (wrap_count != CNT_MAX)) begin
                    wrap_count <= wrap_count + CNT_W'(1);
                end
            end
        end
    end

    // Slot never reaches 15, so level 15 yields a constantly high output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= en && (slot < level_q);
        end
    end

endmodule

// File: tb/tb_staircase_pwm_dac.sv
// Bench for staircase_pwm_dac: DIV=1 and DIV=3 instances checked every clock against
// an arithmetic model derived from the count of enabled clocks since reset.
module tb_staircase_pwm_dac;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] level_in;

    logic       pwm1, fs1, wrap1;
    logic [3:0] lq1;
    logic [7:0] wc1;
    logic       pwm3, fs3, wrap3;
    logic [3:0] lq3;
    logic [7:0] wc3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    staircase_pwm_dac #(.DIV(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .level_in(level_in),
        .pwm_out(pwm1), .frame_start(fs1), .level_q(lq1), .wrap(wrap1), .wrap_count(wc1)
    );

    staircase_pwm_dac #(.DIV(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .level_in(level_in),
        .pwm_out(pwm3), .frame_start(fs3), .level_q(lq3), .wrap(wrap3), .wrap_count(wc3)
    );

    // Model state per instance (index 0: DIV=1, index 1: DIV=3).
    int unsigned m_div [2] = '{1, 3};
    int unsigned m_n   [2];
    logic [3:0]  m_lvl [2];
    int unsigned m_cnt [2];
    logic        m_fs  [2];
    logic        m_wrap[2];
    logic        m_pwm [2];

    // Duty accounting for the DIV=1 instance over whole uninterrupted frames.
    int   duty_acc = 0;
    bit   duty_armed = 0;
    logic [3:0] duty_lvl = '0;

    int   stair_idx = 0;
    logic [3:0] stair_seq [5] = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd15};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0; m_lvl[k] = '0; m_cnt[k] = 0;
            m_fs[k] = 0; m_wrap[k] = 0; m_pwm[k] = 0;
        end
        duty_acc = 0;
        duty_armed = 0;
    endtask

    task automatic check_all();
        chk("pwm1",  8'(pwm1),  8'(m_pwm[0]));
        chk("fs1",   8'(fs1),   8'(m_fs[0]));
        chk("wrap1", 8'(wrap1), 8'(m_wrap[0]));
        chk("lq1",   8'(lq1),   8'(m_lvl[0]));
        chk("wc1",   wc1,       8'(m_cnt[0]));
        chk("pwm3",  8'(pwm3),  8'(m_pwm[1]));
        chk("fs3",   8'(fs3),   8'(m_fs[1]));
        chk("wrap3", 8'(wrap3), 8'(m_wrap[1]));
        chk("lq3",   8'(lq3),   8'(m_lvl[1]));
        chk("wc3",   wc3,       8'(m_cnt[1]));
    endtask

    // One clock: predict from pre-edge inputs, clock, then compare 1 time unit later.
    task automatic cycle();
        int unsigned slot;
        for (int k = 0; k < 2; k++) begin
            slot = (m_n[k] / m_div[k]) % 15;
            m_pwm[k] = en && (slot < int'(m_lvl[k]));
            if (en) m_n[k]++;
            m_fs[k] = en && (m_n[k] % (15 * m_div[k]) == 0);
            m_wrap[k] = m_fs[k] && (level_in < m_lvl[k]);
            if (m_fs[k]) begin
                if (m_wrap[k] && m_cnt[k] < 255) m_cnt[k]++;
                m_lvl[k] = level_in;
            end
        end
        @(posedge clk);
        #1;
        check_all();
        if (!en) duty_armed = 0;
        if (m_fs[0]) begin
            if (duty_armed) chk("duty1", 8'(duty_acc + int'(pwm1)), 8'(duty_lvl));
            duty_acc = 0;
            duty_armed = 1;
            duty_lvl = m_lvl[0];
        end else begin
            duty_acc += int'(pwm1);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b1;
        level_in = 4'd7;
        #2;
        do_reset();

        // Steady duty at 7, then reset mid-frame while level_q = 7.
        run(60);
        run(4);
        do_reset();
        run(35);

        // Full-scale and zero levels.
        level_in = 4'd15;
        run(50);
        level_in = 4'd0;
        run(50);

        // Staircase loop: upstream generator steps on each DIV=1 frame_start.
        do_reset();
        stair_idx = 0;
        level_in = stair_seq[0];
        for (int i = 0; i < 15 * 12; i++) begin
            cycle();
            if (m_fs[0]) begin
                stair_idx = (stair_idx + 1) % 5;
                level_in = stair_seq[stair_idx];
            end
        end
        chk("stair_wraps", wc1, 8'd2);

        // Enable gating at slot 14 of the DIV=1 instance, with level change during the gap.
        level_in = 4'd3;
        run(20);
        for (int guard = 0; guard < 20 && ((m_n[0] % 15) != 14); guard++) cycle();
        chk("at_slot14", 8'(m_n[0] % 15), 8'd14);
        en = 1'b0;
        run(5);
        level_in = 4'd11;
        run(5);
        en = 1'b1;
        cycle();
        chk("gap_latch", 8'(lq1), 8'd11);
        run(40);

        // Saturation: alternate 15/0 each DIV=1 frame for 300+ wrap events.
        do_reset();
        level_in = 4'd15;
        for (int i = 0; i < 15 * 610; i++) begin
            cycle();
            if (m_fs[0]) level_in = (m_lvl[0] == 4'd15) ? 4'd0 : 4'd15;
        end
        chk("sat_wc1", wc1, 8'd255);

        // Randomized traffic with occasional enable drops and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) level_in = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/staircase_pwm_dac.md
# staircase_pwm_dac

Downstream stage of the 4-bit staircase generator: converts each staircase level (0, 1, 3, 7, 15, then back to 0) into a pulse-width-modulated output for an RC-filtered 1-bit DAC. The level is sampled once per fixed 15-slot PWM frame, so the duty cycle equals level/15. A per-frame strobe is exported so the staircase generator can be advanced exactly once per frame. The block also flags staircase wrap-around (the level drop back to 0) and counts wraps for debug and visibility.

## Interface
- DIV, default 1: prescaler ratio. Frame slot advances every DIV clocks. Legal range is 1..65535.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable. When low, the prescaler and slot counter freeze.
- level_in  in  4  staircase level from the upstream generator
- pwm_out  out  1  registered PWM output
- frame_start  out  1  one-cycle strobe in the first clock of each frame. Intended as the upstream step enable.
- level_q  out  4  level latched for the current frame
- wrap  out  1  one-cycle strobe: the newly latched level is lower than the previous one
- wrap_count  out  8  number of wraps seen, saturating at 255

## Operation
- Reset is asynchronous on rst high. Reset values:
  - prescaler = 0, slot = 0, level_q = 0
  - pwm_out = 0, frame_start = 0, wrap = 0, wrap_count = 0
- Prescaler: `pre` counts 0..DIV-1 while en=1. tick = en && (pre == DIV-1). On tick, `pre` returns to 0. With DIV=1, tick = en.
- Slot counter: `slot` is 4 bits and counts 0..14. On tick it increments, or wraps 14→0. The value 15 is never reached.
- Frame boundary: tick && slot==14. At that clock edge:
  - slot ← 0
  - level_q ← level_in
  - frame_start ← 1
  - wrap ← (level_in < level_q)
  - wrap_count increments if wrap is true and wrap_count < 255
- At every other edge, frame_start ← 0 and wrap ← 0.
- PWM: pwm_out ← en && (slot < level_q) at every edge. Results by level:
  - level 0: constantly low
  - level 15: constantly high (slot never reaches 15)
  - level N: high for N slots per frame
- The comparison uses the registered slot and level_q, so pwm_out lags the slot by exactly one clock.
- level_in is only sampled at frame boundaries. Changes between boundaries have no effect. The upstream generator must be enabled by frame_start; clocked freely, its period-5 sequence aliases against the 15-slot frame.
- Comparison is unsigned 4-bit. The drop 15→0 is a wrap. Equal levels are not a wrap.

## Timing
- Frame length is 15·DIV clocks.
- frame_start is high in the first clock where slot==0. It is registered, with no combinational path from inputs.
- level_in → level_q: captured at the boundary edge, usable in the same cycle frame_start is high.
- Latency from level_q change to first pwm_out reflecting it: 1 clock.
- en low: pre and slot hold, pwm_out goes low at the next edge, and no boundary occurs.
- en returning high: the frame resumes from the held slot. No frame restart.
- en low on a would-be boundary cycle: no latch, no strobe. The boundary happens on the next tick.
- Reset mid-frame: all state clears immediately. The first frame after release is a full 15 slots at level 0.
- The first boundary after reset compares against level_q=0, so it never flags a wrap.
- wrap_count saturation: stays at 255 and never rolls over to 0.

## Test plan
- Reset behaviour: DIV=1, assert rst mid-frame while level_q=7 → all outputs 0 immediately. After release, the first frame_start arrives 15 clocks later and pwm_out stays 0 for that frame.
- Duty check: DIV=1, level_in held at 7 → pwm_out is high 7 of every 15 clocks, with the high run starting 1 clock after frame_start. Level 15 → constant high. Level 0 → constant low.
- Staircase loop: a model generator stepped on frame_start feeds 0,1,3,7,15,0 → duty per frame is 0,1,3,7,15,0 slots. wrap pulses once on the 15→0 frame and wrap_count increments to 1.
- Prescaler: DIV=3, level 3 → frame is 45 clocks and pwm_out is high for 9 consecutive clocks per frame.
- Enable gating: drop en for 10 clocks at slot 14 → no frame_start during the gap and pwm_out is low. The boundary occurs on the first tick after en returns, and level_in is latched only then.
- Saturation: force 300 wrap events (alternate level_in 15/0 on each frame) → wrap_count reaches 255 and holds. wrap still pulses on each event.
